apb3_cmd_master: RTL and testbench

APB3_CMD_MASTER -- requirements
Module: apb3_cmd_master

---
 rtl/apb3_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_apb3_cmd_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_cmd_master.sv
// APB3 command master: converts a valid/ready command into one APB3 transfer
// and returns the result on a valid/ready response channel. Only one transfer
// is in flight at a time. An optional wait-state timeout aborts a transfer to
// a slave that never asserts pready.
module apb3_cmd_master #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic [31:0]          pwdata,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // The abort fires on the last permitted ACCESS cycle, when the wait count
    // has reached TIMEOUT-1; a TIMEOUT of zero never aborts.
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [7:0] WAIT_LAST  = 8'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;

    // Next-state and next-output logic; every output is taken from a flop.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_write ? cmd_wdata : 32'h0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = 8'h0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? 32'h0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'h1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= 8'h0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Directed testbench for apb3_cmd_master: drives commands and a scripted APB
// slave, and compares outputs against hand-computed values one cycle at a time.
module tb_apb3_cmd_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vectors;
    int miscompares;

    apb3_cmd_master #(.ADDRWIDTH(12), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // 100 MHz clock
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0;
        cmd_wdata = 32'h0; rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick();
        vectors++; if (psel !== 1'b0 || penable !== 1'b0) begin miscompares++;
            $display("[TB] FAIL reset_psel: got psel=%b penable=%b want 0 0", psel, penable); end
        vectors++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++;
            $display("[TB] FAIL reset_rsp: got v=%b e=%b t=%b want 0 0 0", rsp_valid, rsp_err, rsp_timeout); end
        vectors++; if (paddr !== 12'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0 || pwrite !== 1'b0) begin miscompares++;
            $display("[TB] FAIL reset_data: got paddr=%h pwdata=%h rdata=%h pwrite=%b want zeros", paddr, pwdata, rsp_rdata, pwrite); end
        presetn = 1'b1;
        tick();
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
            $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010; cmd_wdata = 32'hA5A5_0001;
        tick();
        cmd_valid = 1'b0; cmd_wdata = 32'h0;
        vectors++; if (psel !== 1'b1 || penable !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++;
            $display("[TB] FAIL wr_setup: got psel=%b penable=%b cmd_ready=%b want 1 0 0", psel, penable, cmd_ready); end
        vectors++; if (paddr !== 12'h010 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001) begin miscompares++;
            $display("[TB] FAIL wr_setup_bus: got %h %b %h want 010 1 a5a50001", paddr, pwrite, pwdata); end
        tick();
        vectors++; if (psel !== 1'b1 || penable !== 1'b1 || pwdata !== 32'hA5A5_0001) begin miscompares++;
            $display("[TB] FAIL wr_access: got psel=%b penable=%b pwdata=%h want 1 1 a5a50001", psel, penable, pwdata); end
        tick();
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0 || penable !== 1'b0) begin miscompares++;
            $display("[TB] FAIL wr_resp: got v=%b e=%b rdata=%h psel=%b pen=%b want 1 0 0 0 0", rsp_valid, rsp_err, rsp_rdata, psel, penable); end
        tick();
        vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || paddr !== 12'h010) begin miscompares++;
            $display("[TB] FAIL wr_idle: got cmd_ready=%b rsp_valid=%b paddr=%h want 1 0 010", cmd_ready, rsp_valid, paddr); end
    endtask

    task automatic test_read_wait();
        rsp_ready = 1'b1; pready = 1'b0; prdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h024; cmd_wdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0; cmd_addr = 12'hFFF;
        vectors++; if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0 || pwdata !== 32'h0) begin miscompares++;
            $display("[TB] FAIL rd_setup: got psel=%b pen=%b pwrite=%b pwdata=%h want 1 0 0 0", psel, penable, pwrite, pwdata); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++; if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 12'h024) begin miscompares++;
                $display("[TB] FAIL rd_access%0d: got psel=%b pen=%b paddr=%h want 1 1 024", i, psel, penable, paddr); end
            if (i == 4) begin pready = 1'b1; prdata = 32'h1234_5678; end
        end
        tick();
        pready = 1'b0; prdata = 32'h0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0 || psel !== 1'b0) begin miscompares++;
            $display("[TB] FAIL rd_resp: got v=%b rdata=%h e=%b psel=%b want 1 12345678 0 0", rsp_valid, rsp_rdata, rsp_err, psel); end
        tick();
    endtask

    task automatic test_slave_error();
        // pslverr during wait cycles only
        rsp_ready = 1'b1; pready = 1'b0; pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h100; cmd_wdata = 32'h0000_00AA;
        tick();
        cmd_valid = 1'b0;
        tick();
        pslverr = 1'b1;
        tick();
        pslverr = 1'b0; pready = 1'b1;
        tick();
        pready = 1'b0; pslverr = 1'b1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++;
            $display("[TB] FAIL err_ignored: got v=%b e=%b t=%b want 1 0 0", rsp_valid, rsp_err, rsp_timeout); end
        tick();
        // pslverr sampled with pready
        pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h104;
        tick();
        cmd_valid = 1'b0;
        tick();
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h0BAD_0BAD;
        tick();
        pready = 1'b0; pslverr = 1'b0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0BAD_0BAD) begin miscompares++;
            $display("[TB] FAIL err_slave: got v=%b e=%b t=%b rdata=%h want 1 1 0 0bad0bad", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        int count;
        rsp_ready = 1'b1; pready = 1'b0; prdata = 32'hDEAD_BEEF;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200;
        tick();
        cmd_valid = 1'b0;
        count = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (penable === 1'b1) count++;
            else break;
        end
        vectors++; if (count != 16) begin miscompares++;
            $display("[TB] FAIL to_cycles: got %0d ACCESS cycles want 16", count); end
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin miscompares++;
            $display("[TB] FAIL to_resp: got v=%b e=%b t=%b rdata=%h psel=%b want 1 1 1 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel); end
        tick();
        // pready arrives on the 16th ACCESS cycle: normal completion wins
        cmd_valid = 1'b1; cmd_addr = 12'h204;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++; if (penable !== 1'b1) begin miscompares++;
                $display("[TB] FAIL to_late_access%0d: got penable=%b want 1", i, penable); end
            if (i == 16) begin pready = 1'b1; prdata = 32'hCAFE_0001; end
        end
        tick();
        pready = 1'b0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFE_0001) begin miscompares++;
            $display("[TB] FAIL to_late_resp: got v=%b e=%b t=%b rdata=%h want 1 0 0 cafe0001", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        tick();
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0; pready = 1'b1; pslverr = 1'b0; prdata = 32'h55AA_55AA;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        prdata = 32'h0000_0000; pslverr = 1'b1;
        // a new command waits while the response is stalled
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'h1111_0040;
        for (int i = 1; i <= 5; i++) begin
            vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA_55AA || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++;
                $display("[TB] FAIL bp_hold%0d: got v=%b rdata=%h e=%b cmd_ready=%b want 1 55aa55aa 0 0", i, rsp_valid, rsp_rdata, rsp_err, cmd_ready); end
            tick();
        end
        pslverr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        acc1 = -1; acc2 = -1;
        rsp_ready = 1'b1; pready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (cmd_ready === 1'b1) begin
                if (acc1 < 0) acc1 = c;
                else acc2 = c;
            end
            tick();
            if (acc2 >= 0) break;
            if (acc1 >= 0) begin cmd_write = 1'b1; cmd_addr = 12'h044; cmd_wdata = 32'h2222_0044; end
        end
        cmd_valid = 1'b0;
        vectors++; if (acc1 < 0 || acc2 < 0) begin miscompares++;
            $display("[TB] FAIL b2b_accepts: got acc1=%0d acc2=%0d want both accepted", acc1, acc2); end
        vectors++; if (acc2 - acc1 != 4) begin miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles want 4", acc2 - acc1); end
        vectors++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 12'h044 || pwdata !== 32'h2222_0044) begin miscompares++;
            $display("[TB] FAIL b2b_second: got psel=%b pen=%b paddr=%h pwdata=%h want 1 0 044 22220044", psel, penable, paddr, pwdata); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1; pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h300;
        tick();
        cmd_valid = 1'b0;
        tick();
        vectors++; if (psel !== 1'b1 || penable !== 1'b1) begin miscompares++;
            $display("[TB] FAIL rst_mid_pre: got psel=%b pen=%b want 1 1", psel, penable); end
        #3 presetn = 1'b0;
        #1;
        vectors++; if (psel !== 1'b0 || penable !== 1'b0) begin miscompares++;
            $display("[TB] FAIL rst_mid_async: got psel=%b pen=%b want 0 0", psel, penable); end
        tick();
        presetn = 1'b1; pready = 1'b1;
        tick();
        vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin miscompares++;
            $display("[TB] FAIL rst_mid_after: got cmd_ready=%b rsp_valid=%b psel=%b want 1 0 0", cmd_ready, rsp_valid, psel); end
        tick();
        vectors++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin miscompares++;
            $display("[TB] FAIL rst_mid_no_rsp: got rsp_valid=%b psel=%b want 0 0", rsp_valid, psel); end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_slave_error();
        test_timeout();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
